// File: rtl/mole_pkg.sv
// Shared encodings and default timing constants for the whack-a-mole game core.
package mole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] DIFF_EASY = 2'd0;
    localparam logic [1:0] DIFF_MED  = 2'd1;
    localparam logic [1:0] DIFF_HARD = 2'd2;

    localparam int unsigned DEF_TICK_DIV   = 100_000_000;
    localparam int unsigned DEF_SPAWN_EASY = 200_000_000;
    localparam int unsigned DEF_SPAWN_MED  = 120_000_000;
    localparam int unsigned DEF_SPAWN_HARD = 80_000_000;

    // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR with enable; exposes only the low bits the caller consumes.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0]  SEED  = 16'hACE1,
    parameter int unsigned  OUT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] value
);

    // An all-zero seed would lock the register, so it is replaced by 1.
    localparam logic [15:0] RESET_VAL = (SEED == 16'd0) ? 16'd1 : SEED;

    logic [LFSR_W-1:0] lfsr;

    // Shift right, folding the outgoing bit back through the tap mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= RESET_VAL;
        end else if (en) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        end
    end

    assign value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/mole_game_engine.sv
// Whack-a-mole game core: game FSM, countdown, mole spawning, hit scoring, miss counting.
module mole_game_engine
    import mole_pkg::*;
#(
    parameter int unsigned N_HOLES       = 8,
    parameter int unsigned MAX_ACTIVE    = 2,
    parameter int unsigned SCORE_W       = 8,
    parameter int unsigned TIME_W        = 6,
    parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
    parameter int unsigned SPAWN_EASY    = DEF_SPAWN_EASY,
    parameter int unsigned SPAWN_MED     = DEF_SPAWN_MED,
    parameter int unsigned SPAWN_HARD    = DEF_SPAWN_HARD,
    parameter int unsigned WRONG_PENALTY = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               CLK100MHZ,
    input  logic               RST_BTN,
    input  logic               start,
    input  logic [TIME_W-1:0]  gametime,
    input  logic [1:0]         difficulty,
    input  logic [N_HOLES-1:0] hit_strobe,
    output logic [N_HOLES-1:0] mole,
    output logic [N_HOLES-1:0] molehit,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [TIME_W-1:0]  timeleft,
    output logic               running,
    output logic               gameend
);

    localparam int unsigned IDX_W      = $clog2(N_HOLES);
    localparam int unsigned RND_W      = MAX_ACTIVE * IDX_W;
    localparam int unsigned TICK_CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_PERIOD = (SPAWN_EASY > SPAWN_MED)
                                       ? ((SPAWN_EASY > SPAWN_HARD) ? SPAWN_EASY : SPAWN_HARD)
                                       : ((SPAWN_MED > SPAWN_HARD) ? SPAWN_MED : SPAWN_HARD);
    localparam int unsigned SPAWN_CW   = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
    localparam int unsigned K_MED      = (MAX_ACTIVE < 2) ? MAX_ACTIVE : 2;
    localparam int unsigned SUM_W      = SCORE_W + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t               state, state_n;
    logic [1:0]           diff_q, diff_n;
    logic [TICK_CW-1:0]   tick_cnt, tick_n;
    logic [SPAWN_CW-1:0]  spawn_cnt, spawn_n;
    logic [N_HOLES-1:0]   mole_n, molehit_n;
    logic [SCORE_W-1:0]   score_n, misses_n;
    logic [TIME_W-1:0]    timeleft_n;
    logic                 running_n, gameend_n;

    logic [RND_W-1:0]     rnd;
    logic [SPAWN_CW-1:0]  period_last;
    int unsigned          k_active;
    logic [N_HOLES-1:0]   hit, spawn_map;
    logic [SUM_W-1:0]     hit_cnt, miss_cnt, score_sum, miss_sum;
    logic [SCORE_W-1:0]   score_sat;
    logic                 wrong, last_tick, last_second, spawn;

    mole_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (RND_W)
    ) u_lfsr (
        .clk   (CLK100MHZ),
        .rst   (RST_BTN),
        .en    (state == ST_RUN),
        .value (rnd)
    );

    // Spawn period and mole count for the latched difficulty.
    always_comb begin
        period_last = SPAWN_CW'(SPAWN_HARD - 1);
        k_active    = MAX_ACTIVE;
        case (diff_q)
            DIFF_EASY: begin
                period_last = SPAWN_CW'(SPAWN_EASY - 1);
                k_active    = 1;
            end
            DIFF_MED: begin
                period_last = SPAWN_CW'(SPAWN_MED - 1);
                k_active    = K_MED;
            end
            default: ;
        endcase
    end

    // Candidate mole map: OR of one-hot decodes of successive LFSR slices.
    always_comb begin
        spawn_map = '0;
        for (int unsigned j = 0; j < MAX_ACTIVE; j++) begin
            if (j < k_active) begin
                spawn_map = spawn_map | (N_HOLES'(1) << rnd[j*IDX_W +: IDX_W]);
            end
        end
    end

    // State register.
    always_ff @(posedge CLK100MHZ or posedge RST_BTN) begin
        if (RST_BTN) state <= ST_IDLE;
        else         state <= state_n;
    end

    // Next-state and datapath update: hits score against the old map before a spawn replaces it.
    always_comb begin
        state_n     = state;
        diff_n      = diff_q;
        tick_n      = tick_cnt;
        spawn_n     = spawn_cnt;
        mole_n      = mole;
        molehit_n   = '0;
        score_n     = score;
        misses_n    = misses;
        timeleft_n  = timeleft;
        hit         = '0;
        wrong       = 1'b0;
        hit_cnt     = '0;
        miss_cnt    = '0;
        score_sum   = '0;
        miss_sum    = '0;
        score_sat   = '0;
        last_tick   = 1'b0;
        last_second = 1'b0;
        spawn       = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start && (gametime != '0)) begin
                    state_n    = ST_RUN;
                    diff_n     = difficulty;
                    timeleft_n = gametime;
                    score_n    = '0;
                    misses_n   = '0;
                    mole_n     = '0;
                    tick_n     = '0;
                    spawn_n    = '0;
                end
            end
            ST_RUN: begin
                hit   = hit_strobe & mole;
                wrong = |(hit_strobe & ~mole);
                for (int unsigned i = 0; i < N_HOLES; i++) begin
                    hit_cnt  = hit_cnt + SUM_W'(hit[i]);
                    miss_cnt = miss_cnt + SUM_W'(mole[i] & ~hit[i]);
                end
                score_sum = {1'b0, score} + hit_cnt;
                score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
                if ((WRONG_PENALTY != 0) && wrong && (score_sat != '0)) begin
                    score_sat = score_sat - SCORE_W'(1);
                end
                score_n   = score_sat;
                molehit_n = hit;

                last_tick   = (tick_cnt == TICK_CW'(TICK_DIV - 1));
                last_second = last_tick && (timeleft == TIME_W'(1));
                tick_n      = last_tick ? '0 : tick_cnt + TICK_CW'(1);
                if (last_tick) timeleft_n = timeleft - TIME_W'(1);

                spawn   = (spawn_cnt == '0);
                spawn_n = (spawn_cnt == period_last) ? '0 : spawn_cnt + SPAWN_CW'(1);
                mole_n  = mole & ~hit;

                if (last_second) begin
                    // Moles still up when time runs out are not misses.
                    mole_n  = '0;
                    state_n = ST_DONE;
                end else if (spawn) begin
                    miss_sum = {1'b0, misses} + miss_cnt;
                    misses_n = (miss_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : miss_sum[SCORE_W-1:0];
                    mole_n   = spawn_map;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        running_n = (state_n == ST_RUN);
        gameend_n = (state_n == ST_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge CLK100MHZ or posedge RST_BTN) begin
        if (RST_BTN) begin
            diff_q    <= '0;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
            mole      <= '0;
            molehit   <= '0;
            score     <= '0;
            misses    <= '0;
            timeleft  <= '0;
            running   <= 1'b0;
            gameend   <= 1'b0;
        end else begin
            diff_q    <= diff_n;
            tick_cnt  <= tick_n;
            spawn_cnt <= spawn_n;
            mole      <= mole_n;
            molehit   <= molehit_n;
            score     <= score_n;
            misses    <= misses_n;
            timeleft  <= timeleft_n;
            running   <= running_n;
            gameend   <= gameend_n;
        end
    end

endmodule

// File: doc/mole_game_engine.md
Name: mole_game_engine

Overview:
- Parametrised game core for whack-a-mole: owns game state, countdown, mole spawning, hit scoring and miss counting.
- Generalises single-mole picker/score tracker to N_HOLES holes with up to MAX_ACTIVE simultaneous moles, per-difficulty spawn period and optional wrong-hit penalty.
- Sits between debounced button/switch front-ends and the LED, seven-segment and VGA display paths.

Parameters:
- N_HOLES, 8, hole count; power of 2, 2..16.
- MAX_ACTIVE, 2, max moles per spawn, 1..4; MAX_ACTIVE*log2(N_HOLES) <= 16.
- SCORE_W, 8, score/miss counter width.
- TIME_W, 6, game-time width in seconds.
- TICK_DIV, 100_000_000, clock cycles per second tick.
- SPAWN_EASY / SPAWN_MED / SPAWN_HARD, 200_000_000 / 120_000_000 / 80_000_000, cycles between spawns.
- WRONG_PENALTY, 0, 1 = score -1 (saturating at 0) on any cycle with a hit strobe on a non-mole hole.
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 1.

Ports:
- CLK100MHZ  in  1  system clock.
- RST_BTN  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle start pulse.
- gametime  in  TIME_W  game length in seconds, sampled on accepted start.
- difficulty  in  2  0 easy, 1 medium, 2/3 hard; sampled on accepted start.
- hit_strobe  in  N_HOLES  one-cycle per-hole hit pulses from switch edge detect.
- mole  out  N_HOLES  active mole map.
- molehit  out  N_HOLES  one-cycle pulse per successfully hit hole.
- score  out  SCORE_W  hits scored, saturating.
- misses  out  SCORE_W  moles expired unhit, saturating.
- timeleft  out  TIME_W  remaining seconds.
- running  out  1  high in RUN.
- gameend  out  1  high in DONE.

Behaviour:
- Reset (async): state IDLE; all outputs 0; prescaler and spawn counter 0; LFSR = seed.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 and gametime!=0 (cycle t): latch difficulty; timeleft=gametime; clear score, misses and mole; enter RUN at t+1.
  - start with gametime=0 is ignored.
  - start during RUN is ignored.
- RUN timing:
  - Prescaler counts 0..TICK_DIV-1; on wrap, timeleft decrements.
  - When the decrement takes timeleft 1->0: mole=0 next cycle and state becomes DONE.
- Spawn:
  - Spawn counter counts 0..period-1 for the latched difficulty. First spawn fires at t+1; first mole set is visible at t+2.
  - On spawn, every still-set old mole bit adds 1 to misses.
  - The new mole map is the OR of k one-hot fields decoded from successive log2(N_HOLES)-bit LFSR slices, where k = 1 (easy), min(2,MAX_ACTIVE) (medium), MAX_ACTIVE (hard). Duplicate fields merge.
  - LFSR is 16-bit Galois (taps 16,14,13,11) and advances every cycle in RUN.
- Hit handling (registered; score/mole update visible 1 cycle after strobe):
  - h = hit_strobe & mole. score += popcount(h), saturating at 2^SCORE_W-1.
  - Bits of h are cleared from mole; molehit = h for 1 cycle.
  - Wrong hits (hit_strobe & ~mole != 0): penalty applies only if WRONG_PENALTY=1, once per cycle, after the hit add.
- Simultaneous events:
  - Hit and spawn in the same cycle: the hit scores against the old map first; hit bits are not counted as misses; the new map then replaces the old one.
  - Hit on the final tick cycle: scored; unhit moles at game end are NOT counted as misses.
- DONE: gameend=1, running=0, mole=0. score, misses and timeleft (0) hold until the next accepted start.
- Reset asserted mid-game: immediate return to the reset state; no partial update survives.

Decomposition:
- Package mole_pkg:
  - state encoding (IDLE/RUN/DONE);
  - difficulty codes;
  - default spawn periods and TICK_DIV;
  - LFSR tap constant.
- Sub-module mole_lfsr (16-bit Galois LFSR with enable and seed).
- Popcount and saturating add stay inline.

Test Plan (TICK_DIV=10, SPAWN_EASY/MED/HARD=20/12/8, N_HOLES=8, MAX_ACTIVE=2):
- Reset mid-RUN with score=3 -> all outputs 0 the same cycle, state IDLE; LFSR replays the identical mole sequence after the next start.
- start, gametime=3, difficulty=0 -> mole has exactly 1 bit set at t+2; running for 30 cycles; then gameend=1, timeleft=0, mole=0.
- Hard difficulty: strobe both set mole bits in one cycle -> score +2 one cycle later, molehit equals those 2 bits for exactly 1 cycle, mole=0.
- Leave a mole unhit across a spawn -> misses +1; hit it on the spawn cycle instead -> score +1, misses unchanged.
- WRONG_PENALTY=1: score=0 plus a wrong hit -> score stays 0; score=2 plus a wrong hit -> 1; WRONG_PENALTY=0 plus a wrong hit -> no change.
- start with gametime=0 -> stays IDLE; start during RUN -> timeleft is not reloaded; score forced to 255 then a hit -> stays 255.
